// File: rtl/dpram_burst_master.sv
// Burst initiator for one port of the dual-port byte RAM: accepts read/write burst
// commands and drives the RAM strobes from registers, buffering read data in a small FIFO.
module dpram_burst_master #(
  parameter int DEPTH  = 1025,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int OBUF   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wr_en,
  output logic              mem_chipsel,
  output logic              mem_outen,
  input  logic [DATA_W-1:0] mem_dataout
);

  localparam int PTR_W = (OBUF > 1) ? $clog2(OBUF) : 1;
  localparam int CNT_W = $clog2(OBUF + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] issue_left;
  logic [ADDR_W-1:0] pop_left;
  logic              issue_pend;
  logic              pipe_v1;
  logic              pipe_v2;

  logic [DATA_W-1:0] fifo_mem [OBUF];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic              push;
  logic              pop;
  logic              issue;
  logic              wr_fire;
  logic              cmd_fire;
  logic [SUM_W-1:0]  occupancy;
  logic [ADDR_W-1:0] addr_next;

  // Reads in flight are counted against the FIFO so every issued read has a slot waiting for it.
  always_comb begin
    occupancy = SUM_W'(fifo_count) + SUM_W'(pipe_v1) + SUM_W'(pipe_v2);
    issue     = (state == READ) && issue_pend && (occupancy < SUM_W'(OBUF));
    push      = pipe_v2;
    pop       = (fifo_count != '0) && rd_ready;
    wr_fire   = wr_valid && wr_ready;
    cmd_fire  = cmd_valid && cmd_ready;
    addr_next = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
  end

  assign rd_valid = (fifo_count != '0);
  assign rd_data  = fifo_mem[rd_ptr];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      wr_ready    <= 1'b0;
      done        <= 1'b0;
      mem_data    <= '0;
      mem_address <= '0;
      mem_wr_en   <= 1'b0;
      mem_chipsel <= 1'b0;
      mem_outen   <= 1'b0;
      addr        <= '0;
      issue_left  <= '0;
      pop_left    <= '0;
      issue_pend  <= 1'b0;
      pipe_v1     <= 1'b0;
      pipe_v2     <= 1'b0;
    end else begin
      done        <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_chipsel <= 1'b0;
      mem_outen   <= 1'b0;
      pipe_v1     <= issue;
      pipe_v2     <= pipe_v1;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            addr       <= cmd_addr;
            issue_left <= cmd_len;
            pop_left   <= cmd_len;
            cmd_ready  <= 1'b0;
            if (cmd_write) begin
              state    <= WRITE;
              wr_ready <= 1'b1;
            end else begin
              state      <= READ;
              issue_pend <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (wr_fire) begin
            mem_chipsel <= 1'b1;
            mem_wr_en   <= 1'b1;
            mem_address <= addr;
            mem_data    <= wr_data;
            addr        <= addr_next;
            if (issue_left == '0) begin
              done      <= 1'b1;
              state     <= IDLE;
              wr_ready  <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              issue_left <= issue_left - ADDR_W'(1);
            end
          end
        end
        READ: begin
          if (issue) begin
            mem_chipsel <= 1'b1;
            mem_outen   <= 1'b1;
            mem_address <= addr;
            addr        <= addr_next;
            if (issue_left == '0) issue_pend <= 1'b0;
            else                  issue_left <= issue_left - ADDR_W'(1);
          end
          // The burst ends only when the consumer has taken the last beat, not when it was issued.
          if (pop) begin
            if (pop_left == '0) begin
              done      <= 1'b1;
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end else begin
              pop_left <= pop_left - ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dataout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(OBUF - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OBUF - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dpram_burst_master.sv
// Directed bench for dpram_burst_master with a behavioural byte RAM on the memory port.
module tb_dpram_burst_master;

  localparam int DEPTH  = 1025;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int OBUF   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr, cmd_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy, done;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_wr_en, mem_chipsel, mem_outen;
  logic [DATA_W-1:0] mem_dataout;

  int vec_count   = 0;
  int miscompares = 0;
  int cyc         = 0;
  int accept_cyc;
  int first_cyc, last_cyc;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] wbuf [16];
  logic [DATA_W-1:0] got [$];
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [DATA_W-1:0] wr_data_q [$];
  int                wr_cyc_q [$];
  int                rd_issue_cnt = 0;
  int                done_cnt     = 0;

  dpram_burst_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OBUF(OBUF)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .mem_data(mem_data), .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_chipsel(mem_chipsel), .mem_outen(mem_outen), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM with a registered read port, one cycle from sampled address to dataout.
  always @(posedge clk) begin
    if (mem_chipsel) begin
      if (mem_wr_en)      ram[mem_address] <= mem_data;
      else if (mem_outen) mem_dataout      <= ram[mem_address];
    end
  end

  always @(negedge clk) begin
    if (mem_chipsel && mem_wr_en) begin
      wr_addr_q.push_back(mem_address);
      wr_data_q.push_back(mem_data);
      wr_cyc_q.push_back(cyc);
    end
    if (mem_chipsel && mem_outen) rd_issue_cnt++;
    if (done) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Offers a command and returns at the falling edge right after it was accepted.
  task automatic applyStimulus(input logic write, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] len);
    cmd_write = write;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int t = 0; t < 20 && !cmd_ready; t++) @(negedge clk);
    checkOutput("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid  = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic writeBurst(input logic [ADDR_W-1:0] a, input int n);
    applyStimulus(1'b1, a, ADDR_W'(n - 1));
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      for (int t = 0; t < 20 && !wr_ready; t++) @(negedge clk);
      checkOutput($sformatf("wr_ready_beat%0d", i), 32'(wr_ready), 32'd1);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic collectRead(input int n);
    got.delete();
    rd_ready = 1'b1;
    for (int t = 0; t < 200 && got.size() < n; t++) begin
      if (rd_valid) begin
        if (got.size() == 0) first_cyc = cyc;
        got.push_back(rd_data);
        last_cyc = cyc;
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    @(negedge clk);
    checkOutput("rd_beat_count", 32'(got.size()), 32'(n));
  endtask

  initial begin
    int base_w, base_d, base_i;
    logic [ADDR_W-1:0] t3_addr [4];
    t3_addr[0] = 11'h3FF; t3_addr[1] = 11'h400; t3_addr[2] = 11'h000; t3_addr[3] = 11'h001;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;

    // Reset state
    #12;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_mem_strobes", {29'd0, mem_chipsel, mem_wr_en, mem_outen}, 32'd0);
    checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("idle_wr_ready", 32'(wr_ready), 32'd0);

    // Test 1: write burst at 0x010
    for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
    base_w = wr_addr_q.size(); base_d = done_cnt;
    writeBurst(11'h010, 4);
    checkOutput("t1_strobes", 32'(wr_addr_q.size() - base_w), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_addr%0d", i), 32'(wr_addr_q[base_w + i]), 32'h010 + 32'(i));
      checkOutput($sformatf("t1_data%0d", i), 32'(wr_data_q[base_w + i]), 32'hA0 + 32'(i));
      checkOutput($sformatf("t1_ram%0d", i), 32'(ram[16 + i]), 32'hA0 + 32'(i));
    end
    checkOutput("t1_consecutive", 32'(wr_cyc_q[base_w + 3] - wr_cyc_q[base_w]), 32'd3);
    checkOutput("t1_done", 32'(done_cnt - base_d), 32'd1);

    // Test 2: read back with rd_ready high
    base_d = done_cnt;
    applyStimulus(1'b0, 11'h010, 11'd3);
    collectRead(4);
    for (int i = 0; i < got.size(); i++)
      checkOutput($sformatf("t2_data%0d", i), 32'(got[i]), 32'hA0 + 32'(i));
    checkOutput("t2_first_latency", 32'(first_cyc - accept_cyc), 32'd3);
    checkOutput("t2_rate", 32'(last_cyc - first_cyc), 32'd3);
    checkOutput("t2_done", 32'(done_cnt - base_d), 32'd1);
    checkOutput("t2_idle", 32'(busy), 32'd0);

    // Test 3: address wrap at DEPTH-1
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    base_w = wr_addr_q.size();
    writeBurst(11'h3FF, 4);
    checkOutput("t3_strobes", 32'(wr_addr_q.size() - base_w), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t3_addr%0d", i), 32'(wr_addr_q[base_w + i]), 32'(t3_addr[i]));
    applyStimulus(1'b0, 11'h3FF, 11'd3);
    collectRead(4);
    for (int i = 0; i < got.size(); i++)
      checkOutput($sformatf("t3_data%0d", i), 32'(got[i]), 32'h11 * (32'(i) + 1));

    // Test 4: backpressure on an 8-beat read
    for (int i = 0; i < 8; i++) wbuf[i] = 8'h50 + 8'(i);
    writeBurst(11'h100, 8);
    base_i = rd_issue_cnt; base_d = done_cnt;
    applyStimulus(1'b0, 11'h100, 11'd7);
    for (int t = 0; t < 5; t++) @(negedge clk);
    checkOutput("t4_head_mid", 32'(rd_data), 32'h50);
    for (int t = 0; t < 5; t++) @(negedge clk);
    checkOutput("t4_issued_capped", 32'(rd_issue_cnt - base_i), 32'(OBUF));
    checkOutput("t4_rd_valid_held", 32'(rd_valid), 32'd1);
    checkOutput("t4_head_end", 32'(rd_data), 32'h50);
    collectRead(8);
    for (int i = 0; i < got.size(); i++)
      checkOutput($sformatf("t4_data%0d", i), 32'(got[i]), 32'h50 + 32'(i));
    checkOutput("t4_total_issued", 32'(rd_issue_cnt - base_i), 32'd8);
    checkOutput("t4_done", 32'(done_cnt - base_d), 32'd1);

    // Test 5: gapped write beats and a command offered while busy
    base_w = wr_addr_q.size(); base_d = done_cnt;
    applyStimulus(1'b1, 11'h200, 11'd1);
    wr_valid = 1'b1; wr_data = 8'h5A;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    checkOutput("t5_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    checkOutput("t5_strobe1", 32'(mem_wr_en), 32'd1);
    checkOutput("t5_addr1", 32'(mem_address), 32'h200);
    @(negedge clk);
    checkOutput("t5_gap", {30'd0, mem_chipsel, mem_wr_en}, 32'd0);
    checkOutput("t5_cmd_ready_gap", 32'(cmd_ready), 32'd0);
    wr_valid = 1'b1; wr_data = 8'h5B;
    @(negedge clk);
    wr_valid = 1'b0; cmd_valid = 1'b0;
    checkOutput("t5_strobe2", 32'(mem_wr_en), 32'd1);
    checkOutput("t5_addr2", 32'(mem_address), 32'h201);
    checkOutput("t5_data2", 32'(mem_data), 32'h5B);
    checkOutput("t5_done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("t5_idle", 32'(busy), 32'd0);
    checkOutput("t5_no_extra", {30'd0, mem_chipsel, mem_wr_en}, 32'd0);
    @(negedge clk);
    checkOutput("t5_strobes", 32'(wr_addr_q.size() - base_w), 32'd2);
    checkOutput("t5_done", 32'(done_cnt - base_d), 32'd1);
    checkOutput("t5_ram0", 32'(ram[11'h200]), 32'h5A);
    checkOutput("t5_ram1", 32'(ram[11'h201]), 32'h5B);

    // Test 6: reset during a read burst
    applyStimulus(1'b0, 11'h100, 11'd7);
    collectRead(2);
    checkOutput("t6_pre_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("t6_strobes", {29'd0, mem_chipsel, mem_wr_en, mem_outen}, 32'd0);
    checkOutput("t6_mem_address", 32'(mem_address), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_cmd_ready_after", 32'(cmd_ready), 32'd1);
    checkOutput("t6_quiet", 32'(mem_chipsel), 32'd0);
    base_d = done_cnt;
    applyStimulus(1'b0, 11'h010, 11'd3);
    collectRead(4);
    for (int i = 0; i < got.size(); i++)
      checkOutput($sformatf("t6_data%0d", i), 32'(got[i]), 32'hA0 + 32'(i));
    checkOutput("t6_done", 32'(done_cnt - base_d), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
